// File: rtl/vga_draw_arbiter.sv
// vga_draw_arbiter: round-robin sharing of the VGA plot port between two players,
// scanning each granted box row-major and acknowledging the owner when done.
module vga_draw_arbiter #(
  parameter int BOX_W = 8,
  parameter int BOX_H = 4
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       req1,
  input  logic [7:0] x1,
  input  logic [6:0] y1,
  input  logic [2:0] colour1,
  input  logic       req2,
  input  logic [7:0] x2,
  input  logic [6:0] y2,
  input  logic [2:0] colour2,
  output logic       ack1,
  output logic       ack2,
  output logic       busy,
  output logic [7:0] x,
  output logic [6:0] y,
  output logic [2:0] colour,
  output logic       plot
);
  typedef enum logic [1:0] {IDLE, DRAW, ACK} state_t;
  state_t state_q, state_d;
  logic own2_q, own2_d, last2_q, last2_d;
  logic [3:0] cx_q, cx_d, cy_q, cy_d;
  logic [7:0] bx_q, bx_d;
  logic [6:0] by_q, by_d;
  logic [2:0] col_q, col_d;
  logic grant2, cx_last, cy_last;
  // On a tie the player that was not served last wins.
  assign grant2  = req2 && (!req1 || !last2_q);
  assign cx_last = cx_q == 4'(BOX_W - 1);
  assign cy_last = cy_q == 4'(BOX_H - 1);
  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= IDLE;
      own2_q  <= 1'b0;
      last2_q <= 1'b1;
      cx_q    <= '0;
      cy_q    <= '0;
      bx_q    <= '0;
      by_q    <= '0;
      col_q   <= '0;
    end else begin
      state_q <= state_d;
      own2_q  <= own2_d;
      last2_q <= last2_d;
      cx_q    <= cx_d;
      cy_q    <= cy_d;
      bx_q    <= bx_d;
      by_q    <= by_d;
      col_q   <= col_d;
    end
  end
  always_comb begin
    state_d = state_q;
    own2_d  = own2_q;
    last2_d = last2_q;
    cx_d    = cx_q;
    cy_d    = cy_q;
    bx_d    = bx_q;
    by_d    = by_q;
    col_d   = col_q;
    if (state_q == IDLE && (req1 || req2)) begin
      state_d = DRAW;
      own2_d  = grant2;
      last2_d = grant2;
      bx_d    = grant2 ? x2 : x1;
      by_d    = grant2 ? y2 : y1;
      col_d   = grant2 ? colour2 : colour1;
      cx_d    = '0;
      cy_d    = '0;
    end
    if (state_q == DRAW) begin
      cx_d    = cx_last ? 4'd0 : cx_q + 4'd1;
      cy_d    = cx_last ? (cy_last ? 4'd0 : cy_q + 4'd1) : cy_q;
      state_d = (cx_last && cy_last) ? ACK : DRAW;
    end
    if (state_q == ACK) state_d = IDLE;
  end
  assign plot   = state_q == DRAW;
  assign x      = plot ? bx_q + {4'd0, cx_q} : '0;
  assign y      = plot ? by_q + {3'd0, cy_q} : '0;
  assign colour = plot ? col_q : '0;
  assign ack1   = state_q == ACK && !own2_q;
  assign ack2   = state_q == ACK && own2_q;
  assign busy   = state_q != IDLE;
endmodule

// File: tb/tb_vga_draw_arbiter.sv
// tb_vga_draw_arbiter: scoreboard of expected pixels/acks plus a vector table and
// hand-written sequences for round-robin, reset mid-draw and post-grant input changes.
module tb_vga_draw_arbiter;
  logic clk = 0, resetn = 0, req1 = 0, req2 = 0;
  logic [7:0] x1 = 0, x2 = 0;
  logic [6:0] y1 = 0, y2 = 0;
  logic [2:0] colour1 = 0, colour2 = 0;
  logic ack1, ack2, busy, plot;
  logic [7:0] x;
  logic [6:0] y;
  logic [2:0] colour;
  int checks = 0, errors = 0, cyc = 0;
  bit mon_en = 0;
  typedef struct packed {logic is_ack; logic [1:0] acks; logic [7:0] x; logic [6:0] y; logic [2:0] c;} ev_t;
  ev_t q[$];
  typedef struct {
    logic r1; logic [7:0] x1; logic [6:0] y1; logic [2:0] c1;
    logic r2; logic [7:0] x2; logic [6:0] y2; logic [2:0] c2;
    int first;
  } vec_t;

  vga_draw_arbiter #(.BOX_W(8), .BOX_H(4)) dut (
    .clk(clk), .resetn(resetn),
    .req1(req1), .x1(x1), .y1(y1), .colour1(colour1),
    .req2(req2), .x2(x2), .y2(y2), .colour2(colour2),
    .ack1(ack1), .ack2(ack2), .busy(busy),
    .x(x), .y(y), .colour(colour), .plot(plot)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at cycle %0d", n, a, e, cyc);
    end
  endtask

  task automatic flag(input string n);
    checks++;
    errors++;
    $display("FAIL %s at cycle %0d", n, cyc);
  endtask

  task automatic push_box(input int own, input logic [7:0] bx, input logic [6:0] by, input logic [2:0] c);
    for (int j = 0; j < 4; j++)
      for (int i = 0; i < 8; i++)
        q.push_back('{1'b0, 2'b00, 8'(bx + i), 7'(by + j), c});
    q.push_back('{1'b1, (own == 1) ? 2'b10 : 2'b01, 8'd0, 7'd0, 3'd0});
  endtask

  task automatic wait_ack(output int t);
    t = -1;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (ack1 || ack2) begin
        t = cyc;
        break;
      end
    end
    if (t < 0) flag("ack_timeout");
  endtask

  always @(negedge clk) begin
    ev_t e;
    if (mon_en) begin
      if (plot) begin
        if (q.size() == 0 || q[0].is_ack) flag("unexpected_plot");
        else begin
          e = q.pop_front();
          chk("pixel_xyc", {14'd0, x, y, colour}, {14'd0, e.x, e.y, e.c});
        end
      end else chk("idle_xyc", {14'd0, x, y, colour}, 32'd0);
      if (ack1 || ack2) begin
        if (q.size() == 0 || !q[0].is_ack) flag("unexpected_ack");
        else begin
          e = q.pop_front();
          chk("ack_owner", {30'd0, ack1, ack2}, {30'd0, e.acks});
        end
      end
    end
  end

  initial begin
    vec_t v[5];
    int t0, t1, t2, gap;
    v[0] = '{1'b1, 8'd10, 7'd20, 3'b100, 1'b0, 8'd0, 7'd0, 3'd0, 1};
    v[1] = '{1'b0, 8'd0, 7'd0, 3'd0, 1'b1, 8'd50, 7'd60, 3'd2, 2};
    v[2] = '{1'b1, 8'd254, 7'd126, 3'd7, 1'b0, 8'd0, 7'd0, 3'd0, 1};
    v[3] = '{1'b1, 8'd5, 7'd5, 3'd1, 1'b1, 8'd100, 7'd100, 3'd6, 2};
    v[4] = '{1'b1, 8'd0, 7'd0, 3'd3, 1'b1, 8'd200, 7'd0, 3'd5, 2};
    repeat (2) @(negedge clk);
    mon_en = 1;
    chk("reset_outs", {8'd0, plot, x, y, colour, ack1, ack2, busy}, 32'd0);
    resetn = 1;
    for (int k = 0; k < 5; k++) begin
      @(negedge clk);
      req1 = v[k].r1; x1 = v[k].x1; y1 = v[k].y1; colour1 = v[k].c1;
      req2 = v[k].r2; x2 = v[k].x2; y2 = v[k].y2; colour2 = v[k].c2;
      t0 = cyc;
      chk("busy_idle", {31'd0, busy}, 32'd0);
      if (v[k].first == 1) push_box(1, v[k].x1, v[k].y1, v[k].c1);
      else push_box(2, v[k].x2, v[k].y2, v[k].c2);
      if (v[k].r1 && v[k].r2) begin
        if (v[k].first == 1) push_box(2, v[k].x2, v[k].y2, v[k].c2);
        else push_box(1, v[k].x1, v[k].y1, v[k].c1);
      end
      wait_ack(t1);
      chk("ack_latency", t1 - t0, 33);
      if (v[k].first == 1) req1 = 0; else req2 = 0;
      if (v[k].r1 && v[k].r2) begin
        wait_ack(t2);
        chk("second_grant_spacing", t2 - t1, 34);
        req1 = 0;
        req2 = 0;
      end
    end
    resetn = 0;
    repeat (2) @(negedge clk);
    chk("reset2_outs", {8'd0, plot, x, y, colour, ack1, ack2, busy}, 32'd0);
    resetn = 1;
    @(negedge clk);
    x1 = 11; y1 = 22; colour1 = 1; x2 = 33; y2 = 44; colour2 = 6;
    req1 = 1; req2 = 1;
    t0 = cyc;
    push_box(1, 11, 22, 1); push_box(2, 33, 44, 6);
    push_box(1, 11, 22, 1); push_box(2, 33, 44, 6);
    for (int i = 0; i < 4; i++) begin
      wait_ack(t2);
      if (i == 0) chk("rr_first_latency", t2 - t0, 33);
      else chk("rr_spacing", t2 - t1, 34);
      t1 = t2;
      if (i % 2 == 0) req1 = 0; else req2 = 0;
      if (i < 2) begin
        @(negedge clk);
        if (i % 2 == 0) req1 = 1; else req2 = 1;
      end
    end
    @(negedge clk);
    x2 = 50; y2 = 60; colour2 = 2; req2 = 1;
    t0 = cyc;
    push_box(2, 50, 60, 2); push_box(2, 50, 60, 2);
    wait_ack(t1);
    chk("p2_twice_latency", t1 - t0, 33);
    gap = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      if (busy) break;
      gap++;
    end
    chk("busy_gap", gap, 1);
    wait_ack(t2);
    chk("p2_twice_spacing", t2 - t1, 34);
    req2 = 0;
    repeat (2) @(negedge clk);
    chk("no_regrant", {31'd0, busy}, 32'd0);
    x1 = 40; y1 = 10; colour1 = 5; req1 = 1;
    t0 = cyc;
    push_box(1, 40, 10, 5);
    repeat (6) @(negedge clk);
    x1 = 99; y1 = 99; colour1 = 2; req1 = 0;
    wait_ack(t1);
    chk("drop_req_latency", t1 - t0, 33);
    repeat (40) @(negedge clk);
    chk("drop_req_idle", {31'd0, busy}, 32'd0);
    x1 = 70; y1 = 30; colour1 = 6; req1 = 1;
    push_box(1, 70, 30, 6);
    repeat (10) @(negedge clk);
    resetn = 0;
    req1 = 0;
    @(negedge clk);
    chk("reset_mid_draw", {26'd0, plot, x, y, colour, ack1, busy} , 32'd0);
    q.delete();
    resetn = 1;
    repeat (40) @(negedge clk);
    chk("abandoned_idle", {31'd0, busy}, 32'd0);
    x2 = 5; y2 = 100; colour2 = 3; req2 = 1;
    t0 = cyc;
    push_box(2, 5, 100, 3);
    wait_ack(t1);
    chk("after_reset_latency", t1 - t0, 33);
    req2 = 0;
    repeat (3) @(negedge clk);
    chk("queue_drained", q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
